squelch_detector: RTL and testbench

//  Signal-presence detector downstream of the amplitude averager. Compares each new amplitude

---
 rtl/squelch_pkg.sv | 14 +
 rtl/threshold_scaler.sv | 38 +++
 rtl/squelch_detector.sv | 191 +++++++++++++++++++
 tb/tb_squelch_detector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/squelch_pkg.sv
// Shared definitions for the squelch detector: FSM state encoding and the
// fixed fractional width of the Q4.4 threshold gains.
package squelch_pkg;

  localparam int GAIN_FRAC = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/threshold_scaler.sv
// Registered threshold: (average * gain) >> GAIN_FRAC, kept at full width so a
// large gain can push the threshold above any possible amplitude.
module threshold_scaler
  import squelch_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int GBITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NBITS-1:0]             average_i,
  input  logic [GBITS-1:0]             gain_i,
  output logic [NBITS+GBITS-GAIN_FRAC-1:0] threshold_o
);

  localparam int PBITS = NBITS + GBITS;
  localparam int TBITS = PBITS - GAIN_FRAC;

  logic [PBITS-1:0] product;
  logic [TBITS-1:0] threshold_d;
  logic [TBITS-1:0] threshold_q;

  always_comb begin
    product     = {{GBITS{1'b0}}, average_i} * {{NBITS{1'b0}}, gain_i};
    threshold_d = product[PBITS-1:GAIN_FRAC];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold_q <= '0;
    end else begin
      threshold_q <= threshold_d;
    end
  end

  assign threshold_o = threshold_q;

endmodule

// File: rtl/squelch_detector.sv
// Signal-presence detector: hysteresis thresholds scaled from the noise floor,
// attack qualification, hold stretching, and per-event count/peak tracking.
module squelch_detector
  import squelch_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int GBITS = 8,
  parameter int HBITS = 16,
  parameter int CBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next,
  input  logic [NBITS-1:0] amplitude,
  input  logic [NBITS-1:0] average,
  input  logic [GBITS-1:0] on_gain,
  input  logic [GBITS-1:0] off_gain,
  input  logic [7:0]       attack_len,
  input  logic [HBITS-1:0] hold_len,
  output logic             detect,
  output logic             rise,
  output logic             fall,
  output logic [CBITS-1:0] event_count,
  output logic [NBITS-1:0] event_peak
);

  localparam int TBITS = NBITS + GBITS - GAIN_FRAC;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ATTACK = ATTACK;
  localparam logic [1:0] S_ACTIVE = ACTIVE;
  localparam logic [1:0] S_HOLD   = HOLD;

  logic [TBITS-1:0] thrOn;
  logic [TBITS-1:0] thrOff;
  logic [TBITS-1:0] ampExt;
  logic             over;
  logic             under;

  logic [1:0]       state_q,  state_d;
  logic [7:0]       acnt_q,   acnt_d;
  logic [HBITS-1:0] hcnt_q,   hcnt_d;
  logic             detect_q, detect_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic [CBITS-1:0] count_q,  count_d;
  logic [NBITS-1:0] peak_q,   peak_d;

  logic [8:0]       acntInc;
  logic [HBITS:0]   hcntInc;

  threshold_scaler #(.NBITS(NBITS), .GBITS(GBITS)) u_on_scaler (
    .clk        (clk),
    .rst        (rst),
    .average_i  (average),
    .gain_i     (on_gain),
    .threshold_o(thrOn)
  );

  threshold_scaler #(.NBITS(NBITS), .GBITS(GBITS)) u_off_scaler (
    .clk        (clk),
    .rst        (rst),
    .average_i  (average),
    .gain_i     (off_gain),
    .threshold_o(thrOff)
  );

  always_comb begin
    ampExt = {{(TBITS-NBITS){1'b0}}, amplitude};
    over   = ampExt > thrOn;
    under  = ampExt < thrOff;
  end

  // Counter comparisons are done one bit wider so a live config change can
  // never wrap a counter past its limit.
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    hcnt_d  = hcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    acntInc = {1'b0, acnt_q} + 9'd1;
    hcntInc = {1'b0, hcnt_q} + {{HBITS{1'b0}}, 1'b1};

    if (next) begin
      case (state_q)
        S_IDLE: begin
          if (over) begin
            if (attack_len <= 8'd1) begin
              state_d = S_ACTIVE;
              rise_d  = 1'b1;
              acnt_d  = 8'd0;
            end else begin
              state_d = S_ATTACK;
              acnt_d  = 8'd1;
            end
          end
        end
        S_ATTACK: begin
          if (over) begin
            if (acntInc >= {1'b0, attack_len}) begin
              state_d = S_ACTIVE;
              rise_d  = 1'b1;
              acnt_d  = 8'd0;
            end else begin
              acnt_d  = acntInc[7:0];
            end
          end else begin
            state_d = S_IDLE;
            acnt_d  = 8'd0;
          end
        end
        S_ACTIVE: begin
          if (under) begin
            hcnt_d = '0;
            if (hold_len == '0) begin
              state_d = S_IDLE;
              fall_d  = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!under) begin
            state_d = S_ACTIVE;
            hcnt_d  = '0;
          end else if (hcntInc >= {1'b0, hold_len}) begin
            state_d = S_IDLE;
            fall_d  = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d  = hcntInc[HBITS-1:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          acnt_d  = 8'd0;
          hcnt_d  = '0;
        end
      endcase
    end

    detect_d = (state_d == S_ACTIVE) || (state_d == S_HOLD);
  end

  // A new event restarts the peak at the triggering sample; the count sticks at all-ones.
  always_comb begin
    count_d = count_q;
    peak_d  = peak_q;
    if (rise_d) begin
      if (count_q != {CBITS{1'b1}}) begin
        count_d = count_q + {{(CBITS-1){1'b0}}, 1'b1};
      end
      peak_d = amplitude;
    end else if (next && ((state_q == S_ACTIVE) || (state_q == S_HOLD))) begin
      if (amplitude > peak_q) begin
        peak_d = amplitude;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acnt_q   <= 8'd0;
      hcnt_q   <= '0;
      detect_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      state_q  <= state_d;
      acnt_q   <= acnt_d;
      hcnt_q   <= hcnt_d;
      detect_q <= detect_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  assign detect      = detect_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign event_count = count_q;
  assign event_peak  = peak_q;

endmodule

// File: tb/tb_squelch_detector.sv
// Scoreboard bench for squelch_detector: each strobe queues its expected outputs,
// a monitor compares them the half-cycle after the strobe edge.
module tb_squelch_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        next;
  logic [15:0] amplitude;
  logic [15:0] average;
  logic [7:0]  on_gain;
  logic [7:0]  off_gain;
  logic [7:0]  attack_len;
  logic [15:0] hold_len;
  logic        detect;
  logic        rise;
  logic        fall;
  logic [3:0]  event_count;
  logic [15:0] event_peak;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        d;
    logic        r;
    logic        f;
    logic [3:0]  c;
    logic [15:0] p;
  } exp_t;

  exp_t expQ[$];
  logic monStrobe;
  logic monActive;

  // Narrow event counter so saturation is reachable in a short run.
  squelch_detector #(
    .NBITS(16), .GBITS(8), .HBITS(16), .CBITS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next       (next),
    .amplitude  (amplitude),
    .average    (average),
    .on_gain    (on_gain),
    .off_gain   (off_gain),
    .attack_len (attack_len),
    .hold_len   (hold_len),
    .detect     (detect),
    .rise       (rise),
    .fall       (fall),
    .event_count(event_count),
    .event_peak (event_peak)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] amp, input logic d, input logic r,
                               input logic f, input int c, input int p);
    exp_t e;
    e.d = d;
    e.r = r;
    e.f = f;
    e.c = 4'(c);
    e.p = 16'(p);
    @(negedge clk);
    amplitude = amp;
    next      = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    next = 1'b0;
  endtask

  // Monitor: strobed edges are compared against the queue, idle edges must show no pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      monStrobe = (next === 1'b1) && (rst === 1'b0);
      monActive = (rst === 1'b0);
      @(negedge clk);
      if (monStrobe) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty: got strobe, expected queued entry");
        end else begin
          e = expQ.pop_front();
          checkOutput("detect", 32'(detect), 32'(e.d));
          checkOutput("rise", 32'(rise), 32'(e.r));
          checkOutput("fall", 32'(fall), 32'(e.f));
          checkOutput("event_count", 32'(event_count), 32'(e.c));
          checkOutput("event_peak", 32'(event_peak), 32'(e.p));
        end
      end else if (monActive) begin
        checkOutput("rise_idle", 32'(rise), 32'd0);
        checkOutput("fall_idle", 32'(fall), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    rst        = 1'b1;
    next       = 1'b0;
    amplitude  = 16'd0;
    average    = 16'd0;
    on_gain    = 8'd0;
    off_gain   = 8'd0;
    attack_len = 8'd0;
    hold_len   = 16'd0;
    repeat (3) @(negedge clk);

    // Reset must win over a strobe carrying an over-threshold sample.
    amplitude = 16'd500;
    next      = 1'b1;
    @(negedge clk);
    checkOutput("reset_detect", 32'(detect), 32'd0);
    checkOutput("reset_rise", 32'(rise), 32'd0);
    checkOutput("reset_fall", 32'(fall), 32'd0);
    checkOutput("reset_count", 32'(event_count), 32'd0);
    checkOutput("reset_peak", 32'(event_peak), 32'd0);
    next = 1'b0;
    rst  = 1'b0;

    // thr_on = 100*2 = 200, thr_off = 100*1.5 = 150
    average    = 16'd100;
    on_gain    = 8'h20;
    off_gain   = 8'h18;
    attack_len = 8'd3;
    hold_len   = 16'd4;
    repeat (2) @(negedge clk);

    applyStimulus(16'd201, 0, 0, 0, 0, 0);
    applyStimulus(16'd201, 0, 0, 0, 0, 0);
    applyStimulus(16'd201, 1, 1, 0, 1, 201);
    applyStimulus(16'd250, 1, 0, 0, 1, 250);

    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd160, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 1, 0, 0, 1, 250);
    applyStimulus(16'd100, 0, 0, 1, 1, 250);
    applyStimulus(16'd100, 0, 0, 0, 1, 250);

    applyStimulus(16'd201, 0, 0, 0, 1, 250);
    applyStimulus(16'd201, 0, 0, 0, 1, 250);
    applyStimulus(16'd150, 0, 0, 0, 1, 250);
    applyStimulus(16'd201, 0, 0, 0, 1, 250);
    applyStimulus(16'd120, 0, 0, 0, 1, 250);

    attack_len = 8'd0;
    hold_len   = 16'd0;
    applyStimulus(16'd201, 1, 1, 0, 2, 201);
    applyStimulus(16'd100, 0, 0, 1, 2, 201);

    for (int i = 3; i <= 17; i++) begin
      cnt = (i > 15) ? 15 : i;
      applyStimulus(16'd201, 1, 1, 0, cnt, 201);
      applyStimulus(16'd100, 0, 0, 1, cnt, 201);
    end

    applyStimulus(16'd201, 1, 1, 0, 15, 201);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_detect", 32'(detect), 32'd0);
    checkOutput("midrst_fall", 32'(fall), 32'd0);
    checkOutput("midrst_count", 32'(event_count), 32'd0);
    checkOutput("midrst_peak", 32'(event_peak), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_fall_after", 32'(fall), 32'd0);

    // 0xFFFF * 0xFF >> 4 = 0xFEFF0, above any 16-bit amplitude.
    average  = 16'hFFFF;
    on_gain  = 8'hFF;
    off_gain = 8'hFF;
    repeat (2) @(negedge clk);
    applyStimulus(16'hFFFF, 0, 0, 0, 0, 0);
    applyStimulus(16'h8000, 0, 0, 0, 0, 0);
    applyStimulus(16'hFFFF, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
